// File: rtl/calc2_port_requester_if.sv
// Host-side stream, calc2 request/response bus and status lines
// of one calc2 port requester.
interface calc2_port_requester_if;
    logic        h_req_valid;
    logic        h_req_ready;
    logic [3:0]  h_req_cmd;
    logic [31:0] h_req_op1;
    logic [31:0] h_req_op2;
    logic        h_rsp_valid;
    logic [1:0]  h_rsp_code;
    logic [31:0] h_rsp_data;
    logic [1:0]  h_rsp_tag;
    logic [3:0]  req_cmd_out;
    logic [31:0] req_data_out;
    logic [1:0]  req_tag_out;
    logic [1:0]  out_resp;
    logic [31:0] out_data;
    logic [1:0]  out_tag;
    logic [3:0]  busy_tags;
    logic        spurious_err;

    modport master (
        input  h_req_valid, h_req_cmd, h_req_op1, h_req_op2,
        input  out_resp, out_data, out_tag,
        output h_req_ready,
        output h_rsp_valid, h_rsp_code, h_rsp_data, h_rsp_tag,
        output req_cmd_out, req_data_out, req_tag_out,
        output busy_tags, spurious_err
    );

    modport slave (
        output h_req_valid, h_req_cmd, h_req_op1, h_req_op2,
        output out_resp, out_data, out_tag,
        input  h_req_ready,
        input  h_rsp_valid, h_rsp_code, h_rsp_data, h_rsp_tag,
        input  req_cmd_out, req_data_out, req_tag_out,
        input  busy_tags, spurious_err
    );
endinterface

// File: rtl/calc2_port_requester.sv
// Initiator for one calc2 port: issues 2-cycle requests with one of
// 4 tags, tracks outstanding tags with timeouts, returns completions.
module calc2_port_requester #(
    parameter int TIMEOUT_CYC = 64
) (
    input logic             c_clk,
    input logic             reset,
    calc2_port_requester_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA
    } state_t;

    localparam logic [9:0] TMR_LOAD = 10'(TIMEOUT_CYC - 1);

    state_t      state;
    state_t      state_n;
    logic        ready_q;
    logic [31:0] op2_q;
    logic [3:0]  cmd_out_q;
    logic [31:0] data_out_q;
    logic [1:0]  tag_out_q;

    logic [3:0]  busy;
    logic [3:0]  pend;
    logic [9:0]  timer [4];
    logic        rsp_valid_q;
    logic [1:0]  rsp_code_q;
    logic [31:0] rsp_data_q;
    logic [1:0]  rsp_tag_q;
    logic        spur_q;

    logic        hs;
    logic [1:0]  free_tag;
    logic        resp_hit;
    logic        resp_spur;
    logic [3:0]  expire_now;
    logic [3:0]  exp_cand;
    logic        exp_fire;
    logic [1:0]  exp_tag;
    logic [3:0]  rsp_clr;
    logic [3:0]  exp_clr;
    logic [3:0]  busy_n;
    logic [3:0]  pend_n;

    assign hs = (state == IDLE) && ready_q && bus.h_req_valid;

    // Tag allocation, response matching and expiry arbitration
    always_comb begin
        free_tag = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!busy[i]) free_tag = 2'(i);
        end
        resp_hit  = (bus.out_resp != 2'd0) && busy[bus.out_tag];
        resp_spur = (bus.out_resp != 2'd0) && !busy[bus.out_tag];
        for (int i = 0; i < 4; i++) begin
            expire_now[i] = busy[i] && !pend[i] && (timer[i] == 10'd0);
        end
        exp_cand = pend | expire_now;
        // calc2 responses own the completion slot; expiries wait
        exp_fire = !resp_hit && (exp_cand != 4'd0);
        exp_tag  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (exp_cand[i]) exp_tag = 2'(i);
        end
        rsp_clr = resp_hit ? (4'b0001 << bus.out_tag) : 4'd0;
        exp_clr = exp_fire ? (4'b0001 << exp_tag) : 4'd0;
        busy_n  = (busy & ~rsp_clr & ~exp_clr)
                | (hs ? (4'b0001 << free_tag) : 4'd0);
        pend_n  = exp_cand & ~rsp_clr & ~exp_clr;
        state_n = IDLE;
        unique case (state)
            IDLE:    state_n = hs ? CMD : IDLE;
            CMD:     state_n = DATA;
            DATA:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Issue FSM: registered request bus and host ready
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ready_q    <= 1'b0;
            op2_q      <= 32'd0;
            cmd_out_q  <= 4'd0;
            data_out_q <= 32'd0;
            tag_out_q  <= 2'd0;
        end else begin
            state   <= state_n;
            ready_q <= (state_n == IDLE) && (busy_n != 4'hf);
            unique case (state)
                IDLE: begin
                    if (hs) begin
                        cmd_out_q  <= bus.h_req_cmd;
                        data_out_q <= bus.h_req_op1;
                        tag_out_q  <= free_tag;
                        op2_q      <= bus.h_req_op2;
                    end else begin
                        cmd_out_q  <= 4'd0;
                        data_out_q <= 32'd0;
                        tag_out_q  <= 2'd0;
                    end
                end
                CMD: begin
                    cmd_out_q  <= 4'd0;
                    data_out_q <= op2_q;
                    tag_out_q  <= 2'd0;
                end
                default: begin
                    cmd_out_q  <= 4'd0;
                    data_out_q <= 32'd0;
                    tag_out_q  <= 2'd0;
                end
            endcase
        end
    end

    // Outstanding-tag tracking, timers and the completion register
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            busy        <= 4'd0;
            pend        <= 4'd0;
            for (int i = 0; i < 4; i++) timer[i] <= 10'd0;
            rsp_valid_q <= 1'b0;
            rsp_code_q  <= 2'd0;
            rsp_data_q  <= 32'd0;
            rsp_tag_q   <= 2'd0;
            spur_q      <= 1'b0;
        end else begin
            busy <= busy_n;
            pend <= pend_n;
            for (int i = 0; i < 4; i++) begin
                if (hs && (free_tag == 2'(i))) begin
                    timer[i] <= TMR_LOAD;
                end else if (busy[i] && (timer[i] != 10'd0)) begin
                    timer[i] <= timer[i] - 10'd1;
                end
            end
            rsp_valid_q <= resp_hit || exp_fire;
            if (resp_hit) begin
                rsp_code_q <= bus.out_resp;
                rsp_data_q <= bus.out_data;
                rsp_tag_q  <= bus.out_tag;
            end else if (exp_fire) begin
                rsp_code_q <= 2'd3;
                rsp_data_q <= 32'd0;
                rsp_tag_q  <= exp_tag;
            end else begin
                rsp_code_q <= 2'd0;
                rsp_data_q <= 32'd0;
                rsp_tag_q  <= 2'd0;
            end
            spur_q <= spur_q || resp_spur;
        end
    end

    assign bus.h_req_ready  = ready_q;
    assign bus.req_cmd_out  = cmd_out_q;
    assign bus.req_data_out = data_out_q;
    assign bus.req_tag_out  = tag_out_q;
    assign bus.h_rsp_valid  = rsp_valid_q;
    assign bus.h_rsp_code   = rsp_code_q;
    assign bus.h_rsp_data   = rsp_data_q;
    assign bus.h_rsp_tag    = rsp_tag_q;
    assign bus.busy_tags    = busy;
    assign bus.spurious_err = spur_q;

endmodule

// File: tb/tb_calc2_port_requester.sv
// Directed bench for calc2_port_requester: issue, completion order,
// tag reuse, timeout, response/expiry collision, spurious, reset abort.
module tb_calc2_port_requester;

    logic c_clk = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;
    int   c1    = 0;
    int   c3    = 0;
    int   cdum  = 0;

    calc2_port_requester_if bus();

    calc2_port_requester #(.TIMEOUT_CYC(64)) dut (
        .c_clk (c_clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 c_clk = ~c_clk;

    always @(posedge c_clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic check(string name, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic set_resp(logic [1:0] r, logic [1:0] t, logic [31:0] d);
        bus.out_resp = r;
        bus.out_tag  = t;
        bus.out_data = d;
    endtask

    task automatic issue(logic [3:0] cmd, logic [31:0] a, logic [31:0] b,
                         logic [1:0] etag, output int ccmd);
        int n;
        n = 0;
        while (!bus.h_req_ready && n < 20) begin
            tick();
            n++;
        end
        check("ready_wait", {31'd0, bus.h_req_ready}, 32'd1);
        bus.h_req_valid = 1'b1;
        bus.h_req_cmd   = cmd;
        bus.h_req_op1   = a;
        bus.h_req_op2   = b;
        tick();
        bus.h_req_valid = 1'b0;
        ccmd = cyc;
        check("cmd_cmd", {28'd0, bus.req_cmd_out}, {28'd0, cmd});
        check("cmd_data", bus.req_data_out, a);
        check("cmd_tag", {30'd0, bus.req_tag_out}, {30'd0, etag});
        tick();
        check("data_cmd", {28'd0, bus.req_cmd_out}, 32'd0);
        check("data_data", bus.req_data_out, b);
    endtask

    initial begin
        bus.h_req_valid = 1'b0;
        bus.h_req_cmd   = 4'd0;
        bus.h_req_op1   = 32'd0;
        bus.h_req_op2   = 32'd0;
        set_resp(2'd0, 2'd0, 32'd0);

        repeat (3) tick();
        check("rst_ready", {31'd0, bus.h_req_ready}, 32'd0);
        check("rst_rspv", {31'd0, bus.h_rsp_valid}, 32'd0);
        check("rst_busy", {28'd0, bus.busy_tags}, 32'd0);
        check("rst_cmd", {28'd0, bus.req_cmd_out}, 32'd0);
        check("rst_spur", {31'd0, bus.spurious_err}, 32'd0);
        reset = 1'b0;
        tick();
        check("ready_after_rst", {31'd0, bus.h_req_ready}, 32'd1);

        // single add 5 + 7
        issue(4'd1, 32'd5, 32'd7, 2'd0, cdum);
        check("add_busy", {28'd0, bus.busy_tags}, 32'h1);
        set_resp(2'd1, 2'd0, 32'd12);
        tick();
        set_resp(2'd0, 2'd0, 32'd0);
        check("add_rspv", {31'd0, bus.h_rsp_valid}, 32'd1);
        check("add_code", {30'd0, bus.h_rsp_code}, 32'd1);
        check("add_data", bus.h_rsp_data, 32'd12);
        check("add_tag", {30'd0, bus.h_rsp_tag}, 32'd0);
        check("add_busy_clr", {28'd0, bus.busy_tags}, 32'h0);
        check("idle_cmd", {28'd0, bus.req_cmd_out}, 32'd0);
        tick();
        check("add_pulse_1cyc", {31'd0, bus.h_rsp_valid}, 32'd0);

        // four back-to-back ops
        issue(4'd1, 32'hA0, 32'hB0, 2'd0, cdum);
        issue(4'd2, 32'hA1, 32'hB1, 2'd1, cdum);
        issue(4'd5, 32'hA2, 32'hB2, 2'd2, cdum);
        issue(4'd6, 32'hA3, 32'hB3, 2'd3, c3);
        check("all_busy", {28'd0, bus.busy_tags}, 32'hf);

        // fifth op held until tag1 completes
        bus.h_req_valid = 1'b1;
        bus.h_req_cmd   = 4'd1;
        bus.h_req_op1   = 32'h100;
        bus.h_req_op2   = 32'h200;
        tick();
        check("full_ready0", {31'd0, bus.h_req_ready}, 32'd0);
        tick();
        check("full_ready0b", {31'd0, bus.h_req_ready}, 32'd0);
        set_resp(2'd1, 2'd1, 32'h11);
        tick();
        set_resp(2'd0, 2'd0, 32'd0);
        check("t1_rspv", {31'd0, bus.h_rsp_valid}, 32'd1);
        check("t1_tag", {30'd0, bus.h_rsp_tag}, 32'd1);
        check("t1_busy", {28'd0, bus.busy_tags}, 32'hd);
        check("t1_ready", {31'd0, bus.h_req_ready}, 32'd1);
        tick();
        bus.h_req_valid = 1'b0;
        c1 = cyc;
        check("reuse_tag", {30'd0, bus.req_tag_out}, 32'd1);
        check("reuse_data", bus.req_data_out, 32'h100);
        check("reuse_busy", {28'd0, bus.busy_tags}, 32'hf);
        tick();
        check("reuse_op2", bus.req_data_out, 32'h200);

        // out-of-order completions tag2 then tag0
        set_resp(2'd1, 2'd2, 32'h22);
        tick();
        set_resp(2'd2, 2'd0, 32'h33);
        check("ooo2_tag", {30'd0, bus.h_rsp_tag}, 32'd2);
        check("ooo2_data", bus.h_rsp_data, 32'h22);
        check("ooo2_busy", {28'd0, bus.busy_tags}, 32'hb);
        tick();
        set_resp(2'd0, 2'd0, 32'd0);
        check("ooo0_tag", {30'd0, bus.h_rsp_tag}, 32'd0);
        check("ooo0_code", {30'd0, bus.h_rsp_code}, 32'd2);
        check("ooo0_data", bus.h_rsp_data, 32'h33);
        check("ooo0_busy", {28'd0, bus.busy_tags}, 32'ha);

        issue(4'd2, 32'd10, 32'd3, 2'd0, cdum);

        // tag0 response collides with tag3 expiry
        while (cyc < c3 + 63) tick();
        check("pre_exp_quiet", {31'd0, bus.h_rsp_valid}, 32'd0);
        set_resp(2'd2, 2'd0, 32'h44);
        tick();
        set_resp(2'd0, 2'd0, 32'd0);
        check("coll_rsp_tag", {30'd0, bus.h_rsp_tag}, 32'd0);
        check("coll_rsp_code", {30'd0, bus.h_rsp_code}, 32'd2);
        check("coll_rsp_data", bus.h_rsp_data, 32'h44);
        check("coll_busy", {28'd0, bus.busy_tags}, 32'ha);
        tick();
        check("coll_to_v", {31'd0, bus.h_rsp_valid}, 32'd1);
        check("coll_to_code", {30'd0, bus.h_rsp_code}, 32'd3);
        check("coll_to_tag", {30'd0, bus.h_rsp_tag}, 32'd3);
        check("coll_to_data", bus.h_rsp_data, 32'd0);
        check("coll_to_busy", {28'd0, bus.busy_tags}, 32'h2);

        // tag1 timeout exactly 64 cycles after its CMD
        while (cyc < c1 + 63) tick();
        check("t1_early", {31'd0, bus.h_rsp_valid}, 32'd0);
        tick();
        check("t1_to_v", {31'd0, bus.h_rsp_valid}, 32'd1);
        check("t1_to_code", {30'd0, bus.h_rsp_code}, 32'd3);
        check("t1_to_tag", {30'd0, bus.h_rsp_tag}, 32'd1);
        check("t1_to_data", bus.h_rsp_data, 32'd0);
        check("t1_to_busy", {28'd0, bus.busy_tags}, 32'h0);
        tick();
        check("t1_to_1cyc", {31'd0, bus.h_rsp_valid}, 32'd0);

        // response on free tag 3
        set_resp(2'd1, 2'd3, 32'h55);
        tick();
        set_resp(2'd0, 2'd0, 32'd0);
        check("spur_norsp", {31'd0, bus.h_rsp_valid}, 32'd0);
        check("spur_set", {31'd0, bus.spurious_err}, 32'd1);
        tick();
        check("spur_sticky", {31'd0, bus.spurious_err}, 32'd1);

        // reset during DATA
        bus.h_req_valid = 1'b1;
        bus.h_req_cmd   = 4'd5;
        bus.h_req_op1   = 32'd1;
        bus.h_req_op2   = 32'd2;
        tick();
        bus.h_req_valid = 1'b0;
        check("ra_cmd_tag", {30'd0, bus.req_tag_out}, 32'd0);
        tick();
        check("ra_data", bus.req_data_out, 32'd2);
        reset = 1'b1;
        #1;
        check("ra_req_data", bus.req_data_out, 32'd0);
        check("ra_req_cmd", {28'd0, bus.req_cmd_out}, 32'd0);
        check("ra_busy", {28'd0, bus.busy_tags}, 32'd0);
        check("ra_ready", {31'd0, bus.h_req_ready}, 32'd0);
        check("ra_spur", {31'd0, bus.spurious_err}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("ra_ready_rel", {31'd0, bus.h_req_ready}, 32'd1);
        check("ra_rspv", {31'd0, bus.h_rsp_valid}, 32'd0);
        repeat (3) tick();
        check("ra_no_stray", {31'd0, bus.h_rsp_valid}, 32'd0);
        check("ra_busy_end", {28'd0, bus.busy_tags}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
